// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus write arbiters.
//   arb_state_e : arbiter FSM states
//   BUS_DW      : default bus data width
//   rr_next()   : round-robin scan, nearest requester after rr_last wins
package bus_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int BUS_DW   = 16;
  localparam int MAX_NREQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_res_t;

  // Scans from the farthest candidate down to the nearest one so that the
  // nearest requester after rr_last overwrites any earlier hit.
  function automatic rr_res_t rr_next(input logic [MAX_NREQ-1:0] req,
                                      input logic [2:0]          rr_last,
                                      input int                  nreq);
    rr_res_t res;
    int      idx;
    res = '0;
    for (int k = MAX_NREQ; k >= 1; k--) begin
      if (k <= nreq) begin
        idx = (int'(rr_last) + k) % nreq;
        if (req[idx]) begin
          res.found = 1'b1;
          res.idx   = 3'(idx);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_write_arbiter_if.sv
// Requester/bus side signal bundle of the write arbiter.
//   master : requester agents (drive req/last/wdata, observe grant and bus)
//   slave  : arbiter (observe requests, drive grant and registered bus)
interface bus_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [IW-1:0]      owner;
  logic               busy;
  logic [DW-1:0]      bus_data;
  logic               bus_we;

  modport master (output req, last, wdata,
                  input  gnt, owner, busy, bus_data, bus_we);
  modport slave  (input  req, last, wdata,
                  output gnt, owner, busy, bus_data, bus_we);
endinterface

// File: rtl/bus_write_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req_i     : request vector
//   rr_last_i : index granted most recently (lowest priority now)
//   winner_o  : chosen index, meaningful when valid_o
//   valid_o   : at least one request present
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_last_i,
  output logic [IW-1:0]   winner_o,
  output logic            valid_o
);

  rr_res_t res;
  logic    unused_idx;

  always_comb res = rr_next(MAX_NREQ'(req_i), 3'(rr_last_i), NREQ);

  assign winner_o   = res.idx[IW-1:0];
  assign valid_o    = res.found;
  // upper index bits are always zero when NREQ < 8
  assign unused_idx = ^res.idx;

endmodule

// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter sharing one registered write bus among NREQ requesters.
//   clk, rst_n : bus clock, asynchronous active-low reset
//   bus        : slave side of bus_write_arbiter_if
//                req/last/wdata in; gnt/owner/busy/bus_data/bus_we out
// A grant lasts until the owner drops req, flags last, or reaches MAX_HOLD
// beats. Every release passes through one IDLE (arbitration) cycle.
module bus_write_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = BUS_DW,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_write_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q,    state_d;
  logic [NREQ-1:0] gnt_q,      gnt_d;
  logic [IW-1:0]   owner_q,    owner_d;
  logic [IW-1:0]   rr_last_q,  rr_last_d;
  logic [7:0]      hold_q,     hold_d;
  logic [DW-1:0]   bus_data_q, bus_data_d;
  logic            bus_we_q,   bus_we_d;

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [DW-1:0]   own_wdata;
  logic            own_req, own_last, beat;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i     (bus.req),
    .rr_last_i (rr_last_q),
    .winner_o  (win),
    .valid_o   (win_vld)
  );

  // Only the owner's slice can reach the bus.
  always_comb begin
    own_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (owner_q == IW'(i)) own_wdata = bus.wdata[i*DW +: DW];
  end

  assign own_req  = bus.req[owner_q];
  assign own_last = bus.last[owner_q];
  assign beat     = (state_q == GRANT) && own_req && gnt_q[owner_q];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    hold_d     = hold_q;
    bus_data_d = bus_data_q;
    bus_we_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = GRANT;
          gnt_d     = NREQ'(1) << win;
          owner_d   = win;
          rr_last_d = win;
          hold_d    = 8'd0;
        end
      end
      GRANT: begin
        if (beat) begin
          bus_we_d   = 1'b1;
          bus_data_d = own_wdata;
          hold_d     = hold_q + 8'd1;
          // the releasing beat is still written
          if (own_last || (hold_q + 8'd1 == 8'(MAX_HOLD))) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_last_q  <= IW'(NREQ - 1);
      hold_q     <= 8'd0;
      bus_data_q <= '0;
      bus_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      hold_q     <= hold_d;
      bus_data_q <= bus_data_d;
      bus_we_q   <= bus_we_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q == GRANT);
  assign bus.bus_data = bus_data_q;
  assign bus.bus_we   = bus_we_q;

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Directed bench for bus_write_arbiter (NREQ=4, DW=16, MAX_HOLD=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_bus_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  bus_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus_if ();

  bus_write_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int i, input logic [DW-1:0] v);
    bus_if.wdata[i*DW +: DW] = v;
  endtask

  // gnt / busy / bus_we in one call
  task automatic chk_ctl(input string tag, input logic [3:0] g, input logic b, input logic we);
    chk({tag, ".gnt"},  32'(bus_if.gnt),    32'(g));
    chk({tag, ".busy"}, 32'(bus_if.busy),   32'(b));
    chk({tag, ".we"},   32'(bus_if.bus_we), 32'(we));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus_if.req   = '0;
    bus_if.last  = '0;
    bus_if.wdata = '0;

    // ---------------- reset state
    #3;
    chk_ctl("rst", 4'b0000, 1'b0, 1'b0);
    chk("rst.owner", 32'(bus_if.owner),    32'd0);
    chk("rst.data",  32'(bus_if.bus_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // all requesting after reset: requester 0 first
    bus_if.req = 4'b1111;
    tick();
    chk_ctl("first", 4'b0001, 1'b1, 1'b0);
    chk("first.owner", 32'(bus_if.owner), 32'd0);
    bus_if.req = 4'b0000;
    tick();                               // owner dropped req: release
    chk_ctl("first.rel", 4'b0000, 1'b0, 1'b0);
    tick();

    // ---------------- single burst on requester 1
    bus_if.req = 4'b0010;
    set_wd(1, 16'hdead);
    set_wd(2, 16'h5555);                  // non-owner data must never show
    tick();
    chk_ctl("sb.gnt", 4'b0010, 1'b1, 1'b0);
    chk("sb.owner", 32'(bus_if.owner), 32'd1);
    tick();
    chk_ctl("sb.b0", 4'b0010, 1'b1, 1'b1);
    chk("sb.b0.data", 32'(bus_if.bus_data), 32'hdead);
    set_wd(1, 16'hbeef);
    bus_if.last = 4'b0010;
    tick();
    chk_ctl("sb.b1", 4'b0000, 1'b0, 1'b1);
    chk("sb.b1.data", 32'(bus_if.bus_data), 32'hbeef);
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    tick();
    chk_ctl("sb.idle", 4'b0000, 1'b0, 1'b0);
    chk("sb.idle.data", 32'(bus_if.bus_data), 32'hbeef);

    // ---------------- round robin 0,2,0,2 (fresh reset -> 0 first)
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_wd(0, 16'h1111);
    set_wd(2, 16'h2222);
    bus_if.req  = 4'b0101;
    bus_if.last = 4'b0101;
    for (int r = 0; r < 4; r++) begin
      tick();                             // arbitration edge
      chk_ctl($sformatf("rr%0d.g", r), (r % 2 == 0) ? 4'b0001 : 4'b0100, 1'b1, 1'b0);
      tick();                             // single last beat, then IDLE
      chk_ctl($sformatf("rr%0d.w", r), 4'b0000, 1'b0, 1'b1);
      chk($sformatf("rr%0d.data", r), 32'(bus_if.bus_data),
          (r % 2 == 0) ? 32'h1111 : 32'h2222);
    end
    bus_if.req  = 4'b0000;
    bus_if.last = 4'b0000;
    tick();
    chk_ctl("rr.end", 4'b0000, 1'b0, 1'b0);

    // ---------------- forced release after 8 beats (rr_last=2 -> 3 wins)
    bus_if.req = 4'b1001;
    set_wd(0, 16'h00a0);
    tick();
    chk_ctl("fr.gnt", 4'b1000, 1'b1, 1'b0);
    chk("fr.owner", 32'(bus_if.owner), 32'd3);
    for (int k = 0; k < 8; k++) begin
      set_wd(3, 16'h3000 + 16'(k));
      tick();
      chk_ctl($sformatf("fr.b%0d", k), (k < 7) ? 4'b1000 : 4'b0000, k < 7, 1'b1);
      chk($sformatf("fr.b%0d.data", k), 32'(bus_if.bus_data), 32'h3000 + 32'(k));
    end
    tick();                               // dead cycle, requester 0 wins
    chk_ctl("fr.next", 4'b0001, 1'b1, 1'b0);
    chk("fr.next.owner", 32'(bus_if.owner), 32'd0);

    // ---------------- req drop after 2 beats (owner 0)
    bus_if.req = 4'b0001;
    set_wd(0, 16'h00a1);
    tick();
    chk_ctl("rd.b0", 4'b0001, 1'b1, 1'b1);
    chk("rd.b0.data", 32'(bus_if.bus_data), 32'h00a1);
    set_wd(0, 16'h00a2);
    tick();
    chk_ctl("rd.b1", 4'b0001, 1'b1, 1'b1);
    chk("rd.b1.data", 32'(bus_if.bus_data), 32'h00a2);
    bus_if.req = 4'b0000;
    set_wd(0, 16'h00ff);
    tick();
    chk_ctl("rd.drop", 4'b0000, 1'b0, 1'b0);
    chk("rd.drop.data", 32'(bus_if.bus_data), 32'h00a2);
    tick();

    // ---------------- reset during beat 3 of 5 (requester 1)
    bus_if.req = 4'b0010;
    tick();
    chk_ctl("rm.gnt", 4'b0010, 1'b1, 1'b0);
    set_wd(1, 16'h00b1);
    tick();
    chk_ctl("rm.b0", 4'b0010, 1'b1, 1'b1);
    set_wd(1, 16'h00b2);
    tick();
    chk_ctl("rm.b1", 4'b0010, 1'b1, 1'b1);
    chk("rm.b1.data", 32'(bus_if.bus_data), 32'h00b2);
    set_wd(1, 16'h00b3);
    #2;
    rst_n = 1'b0;                         // asynchronous, mid-cycle
    #1;
    chk_ctl("rm.rst", 4'b0000, 1'b0, 1'b0);
    chk("rm.rst.data",  32'(bus_if.bus_data), 32'd0);
    chk("rm.rst.owner", 32'(bus_if.owner),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();                               // new arbitration, no write yet
    chk_ctl("rm.arb", 4'b0010, 1'b1, 1'b0);
    chk("rm.arb.data", 32'(bus_if.bus_data), 32'd0);
    tick();
    chk_ctl("rm.beat", 4'b0010, 1'b1, 1'b1);
    chk("rm.beat.data", 32'(bus_if.bus_data), 32'h00b3);
    bus_if.req = 4'b0000;
    tick();
    chk_ctl("rm.end", 4'b0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
